fifo_frame_writer: RTL and testbench
====================================

# fifo_frame_writer

Write-side producer for the team's asynchronous FIFO, clocked in the write domain. Accepts a valid/ready word stream with end-of-frame marker, drives the FIFO write port (Write_Enable, Data_In, Full), and appends one tagged trailer word per frame carrying the payload length. Frames longer than MAX_LEN are split into continuation frames. The read-domain consumer recovers frame boundaries from the tag bit alone.

## Interface
- DATA_WIDTH, 8: FIFO word width. Payload is DATA_WIDTH-1 bits; MSB is the trailer tag.
- MAX_LEN, 63: maximum payload words per frame. Legal range is 1..2^(DATA_WIDTH-2)-1.
- CNT_WIDTH, 16: width of frame_count.

Ports:
- Write_Clock  in  1  write-domain clock.
- Write_Reset_Enable  in  1  reset, asynchronous, active-low, clock Write_Clock.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  upstream ready.
- s_data  in  DATA_WIDTH-1  payload word.
- s_last  in  1  last word of frame, qualified by s_valid.
- Write_Enable  out  1  FIFO write request, registered.
- Data_In  out  DATA_WIDTH  FIFO write data, registered.
- Full  in  1  FIFO full, write-domain.
- frame_count  out  CNT_WIDTH  trailers written into FIFO, wraps.
- busy  out  1  state != IDLE or Write_Enable high.

## Operation
- Word format (MSB-first): payload word is {0, s_data}. Trailer word is {1, cont, len[DATA_WIDTH-3:0]}.
  - len = payload words in the frame, 1..MAX_LEN.
  - cont = 1 means the frame was split at MAX_LEN and the next frame continues it.
- Output stage is a single register (Write_Enable = valid, Data_In = word).
  - A held word stays stable until the FIFO takes it, i.e. Write_Enable && !Full at a Write_Clock edge.
  - The stage is free when Write_Enable is 0 or the word is being taken this cycle.
- s_ready = (state != TRAILER) && stage free. It is combinational from Full.
- Accept = s_valid && s_ready. An accepted word loads {0, s_data} into the stage.
- FSM states:
  - IDLE
    - On accept: len <= 1.
    - If s_last or MAX_LEN == 1, go to TRAILER with cont = !s_last. Otherwise go to PAYLOAD.
  - PAYLOAD
    - On accept: len <= len+1.
    - If s_last, go to TRAILER with cont = 0.
    - Else if len+1 == MAX_LEN, go to TRAILER with cont = 1.
  - TRAILER
    - s_ready = 0.
    - When the stage is free, load the trailer word, clear len, and go to IDLE.
- Beats after a cont=1 split start a new frame in IDLE. No data is dropped.
- frame_count increments when a word with MSB=1 is taken by the FIFO.
- Reset values: state IDLE, len 0, Write_Enable 0, Data_In 0, frame_count 0, busy 0. s_ready is forced 0 while Write_Reset_Enable is low.
- Reset mid-frame: the partial frame and any held word are discarded and no trailer is emitted. The FIFO write side shares this reset.
- s_data or s_last changing while s_valid && !s_ready is an upstream protocol violation; behaviour is unspecified.

## Timing
- Accept at edge N: Write_Enable=1 after edge N. The FIFO writes at edge N+1 if Full=0; otherwise the word is held.
- Steady state: 1 word/cycle while Full=0. Each frame costs exactly one extra cycle for its trailer.
- Full rising while Write_Enable=1: word held, s_ready=0. Full falling: the word is taken that edge and s_ready rises in the same cycle.
- Trailer load and FIFO take of the last payload word occur at the same edge when Full=0.
- frame_count updates at the edge where the trailer is taken. busy drops in the cycle after that edge.

## Structure
- Package fifo_frame_pkg holds:
  - state enum {IDLE, PAYLOAD, TRAILER};
  - TAG_BIT = DATA_WIDTH-1 and CONT_BIT = DATA_WIDTH-2;
  - a trailer-pack function;
  - an elaboration check on the MAX_LEN range.
- One sub-module, fifo_write_stage: single-entry valid/ready output register with ready = !Full. The FSM and counters stay in the top.

## Test plan
- 3-word frame 0x11,0x22,0x33 (last on 3rd), Full=0 → FIFO receives 0x11,0x22,0x33,0x83 on consecutive edges; frame_count=1; s_ready low exactly one cycle.
- 70-word frame with MAX_LEN=63 → 63 payload words then 0xFF (cont=1, len=63), then 7 words then 0x87; frame_count=2.
- Full held high 5 cycles while a word is in the stage → Data_In stable and Write_Enable=1 throughout, s_ready=0, nothing lost; drains on the first Full=0 edge.
- Back-to-back 1-word frames 0x05,0x06 → FIFO sequence 0x05,0x81,0x06,0x81; the second frame is accepted the cycle after TRAILER.
- Write_Reset_Enable pulsed low after word 2 of a 4-word frame → Write_Enable=0, Data_In=0, frame_count=0; the next frame's trailer reports only its own length.
- Random s_valid and Full, 1000 frames of random length → scoreboard reconstructs every frame exactly and the trailer len values are correct.

Source files
------------

// File: rtl/fifo_frame_pkg.sv
// Shared definitions for the FIFO frame writer: state encoding, word-format
// bit positions, trailer packing and parameter range checking.
package fifo_frame_pkg;

   localparam int FF_DATA_WIDTH = 8;
   localparam int FF_MAX_LEN    = 63;
   localparam int FF_CNT_WIDTH  = 16;

   localparam int TAG_BIT  = FF_DATA_WIDTH - 1;
   localparam int CONT_BIT = FF_DATA_WIDTH - 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      TRAILER = 2'd2
   } frame_state_t;

   // Trailer word {1, cont, len} for a FIFO word of dw bits; the caller
   // truncates the result to its own width.
   function automatic logic [31:0] pack_trailer(input int          dw,
                                                input logic        cont,
                                                input logic [31:0] len);
      logic [31:0] w_word;
      w_word         = len & ((32'd1 << (dw - 2)) - 32'd1);
      w_word[dw - 1] = 1'b1;
      w_word[dw - 2] = cont;
      return w_word;
   endfunction

   // The length field is dw-2 bits wide, so MAX_LEN must fit in it.
   function automatic bit max_len_legal(input int dw, input int max_len);
      return (max_len >= 1) && (max_len <= (1 << (dw - 2)) - 1);
   endfunction

endpackage

// File: rtl/fifo_write_stage.sv
// Single-entry output register feeding the FIFO write port. A held word
// stays put until the FIFO takes it; the stage is free when empty or draining.
import fifo_frame_pkg::*;

module fifo_write_stage #(
   parameter int DATA_WIDTH = FF_DATA_WIDTH
) (
   input  logic                  Write_Clock,
   input  logic                  Write_Reset_Enable,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_full,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_free,
   output logic                  o_taken
);

   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data;

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_taken = r_valid && !i_full;
   assign o_free  = !r_valid || !i_full;

   // The top only raises i_load while o_free is high, so a load never
   // overwrites a word the FIFO has not taken.
   always_ff @(posedge Write_Clock or negedge Write_Reset_Enable) begin
      if (!Write_Reset_Enable) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (o_taken) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_frame_writer.sv
// Write-domain producer for the async FIFO: forwards payload words and
// appends one tagged length trailer per frame, splitting frames at MAX_LEN.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | no frame open; next accepted word starts a frame
//   PAYLOAD | frame open, len words accepted so far
//   TRAILER | frame closed; waiting for the stage to load the trailer
import fifo_frame_pkg::*;

module fifo_frame_writer #(
   parameter int DATA_WIDTH = FF_DATA_WIDTH,
   parameter int MAX_LEN    = FF_MAX_LEN,
   parameter int CNT_WIDTH  = FF_CNT_WIDTH
) (
   input  logic                  Write_Clock,
   input  logic                  Write_Reset_Enable,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-2:0] s_data,
   input  logic                  s_last,
   output logic                  Write_Enable,
   output logic [DATA_WIDTH-1:0] Data_In,
   input  logic                  Full,
   output logic [CNT_WIDTH-1:0]  frame_count,
   output logic                  busy
);

   localparam int              LW     = DATA_WIDTH - 2;
   localparam logic [LW-1:0]   L_MAX  = LW'(MAX_LEN);
   localparam bit              L_ONE  = (MAX_LEN == 1);

   if (!max_len_legal(DATA_WIDTH, MAX_LEN)) begin : g_bad_max_len
      $error("fifo_frame_writer: MAX_LEN outside 1..2^(DATA_WIDTH-2)-1");
   end

   frame_state_t          r_state;
   logic [LW-1:0]         r_len;
   logic                  r_cont;
   logic [CNT_WIDTH-1:0]  r_frame_count;

   logic                  w_free;
   logic                  w_taken;
   logic                  w_accept;
   logic                  w_load_trl;
   logic                  w_load;
   logic [DATA_WIDTH-1:0] w_trailer;
   logic [DATA_WIDTH-1:0] w_load_data;
   logic [LW-1:0]         w_len_inc;

   assign s_ready     = Write_Reset_Enable && (r_state != TRAILER) && w_free;
   assign w_accept    = s_valid && s_ready;
   assign w_load_trl  = (r_state == TRAILER) && w_free;
   assign w_load      = w_accept || w_load_trl;
   assign w_len_inc   = r_len + LW'(1);
   assign w_trailer   = DATA_WIDTH'(pack_trailer(DATA_WIDTH, r_cont, 32'(r_len)));
   assign w_load_data = w_accept ? {1'b0, s_data} : w_trailer;

   fifo_write_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_stage (
      .Write_Clock        (Write_Clock),
      .Write_Reset_Enable (Write_Reset_Enable),
      .i_load             (w_load),
      .i_data             (w_load_data),
      .i_full             (Full),
      .o_valid            (Write_Enable),
      .o_data             (Data_In),
      .o_free             (w_free),
      .o_taken            (w_taken)
   );

   // The trailer is built from r_len/r_cont as they stand at the loading
   // edge, so clearing them on that same edge is safe.
   always_ff @(posedge Write_Clock or negedge Write_Reset_Enable) begin
      if (!Write_Reset_Enable) begin
         r_state <= IDLE;
         r_len   <= '0;
         r_cont  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_len <= LW'(1);
                  if (s_last || L_ONE) begin
                     r_state <= TRAILER;
                     r_cont  <= !s_last;
                  end else begin
                     r_state <= PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               if (w_accept) begin
                  r_len <= w_len_inc;
                  if (s_last) begin
                     r_state <= TRAILER;
                     r_cont  <= 1'b0;
                  end else if (w_len_inc == L_MAX) begin
                     r_state <= TRAILER;
                     r_cont  <= 1'b1;
                  end
               end
            end
            TRAILER: begin
               if (w_free) begin
                  r_state <= IDLE;
                  r_len   <= '0;
                  r_cont  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_len   <= '0;
               r_cont  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Write_Clock or negedge Write_Reset_Enable) begin
      if (!Write_Reset_Enable) begin
         r_frame_count <= '0;
      end else if (w_taken && Data_In[DATA_WIDTH-1]) begin
         r_frame_count <= r_frame_count + CNT_WIDTH'(1);
      end
   end

   assign frame_count = r_frame_count;
   assign busy        = (r_state != IDLE) || Write_Enable;

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Directed and randomized bench for fifo_frame_writer; a negedge monitor
// records every word the FIFO takes and compares against hand-built lists.
module tb_fifo_frame_writer;

   localparam int DW = 8;

   logic          clk       = 1'b0;
   logic          rst_b     = 1'b0;
   logic          s_valid   = 1'b0;
   logic          s_last    = 1'b0;
   logic [DW-2:0] s_data    = '0;
   logic          full_dir  = 1'b0;
   logic          full_rnd  = 1'b0;
   logic          rand_mode = 1'b0;
   logic          full;
   logic          s_ready;
   logic          we;
   logic [DW-1:0] din;
   logic [15:0]   fcnt;
   logic          busy;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;
   int last_acc = 0;

   logic [7:0] cap_q[$];
   int         cap_cyc[$];
   logic [7:0] exp_q[$];

   assign full = rand_mode ? full_rnd : full_dir;

   fifo_frame_writer #(
      .DATA_WIDTH (8),
      .MAX_LEN    (63),
      .CNT_WIDTH  (16)
   ) dut (
      .Write_Clock        (clk),
      .Write_Reset_Enable (rst_b),
      .s_valid            (s_valid),
      .s_ready            (s_ready),
      .s_data             (s_data),
      .s_last             (s_last),
      .Write_Enable       (we),
      .Data_In            (din),
      .Full               (full),
      .frame_count        (fcnt),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      full_rnd = ($urandom_range(0, 3) == 0);
   end

   // Inputs only change at posedge+1, so the negedge view is what the next edge sees.
   always @(negedge clk) begin
      if (rst_b && we && !full) begin
         cap_q.push_back(din);
         cap_cyc.push_back(cyc);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", n_bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [6:0] d, input logic l);
      bit ok;
      ok      = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (s_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      last_acc = cyc;
      s_valid  = 1'b0;
      s_last   = 1'b0;
      if (!ok) check("send_timeout", 32'(ok), 32'd1);
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge clk);
         if (!busy) ok = 1'b1;
      end
      if (!ok) check("drain_timeout", 32'(ok), 32'd1);
      tick();
   endtask

   task automatic clear_q();
      cap_q.delete();
      cap_cyc.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      tick();
      tick();
      rst_b = 1'b1;
      tick();
      clear_q();
   endtask

   task automatic compare_q(input string tag);
      check({tag, "_len"}, cap_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
         check($sformatf("%s[%0d]", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      int a1;
      int a2;
      int ntr;
      int chunk;
      int flen;
      logic [6:0] d;

      // Reset values, including s_ready forced low while in reset
      #2;
      check("rst_we", 32'(we), 32'd0);
      check("rst_din", 32'(din), 32'd0);
      check("rst_fcnt", 32'(fcnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(s_ready), 32'd0);
      tick();
      tick();
      rst_b = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(s_ready), 32'd1);
      tick();

      // 3-word frame, Full low
      clear_q();
      send_word(7'h11, 1'b0);
      send_word(7'h22, 1'b0);
      send_word(7'h33, 1'b1);
      @(negedge clk);
      check("t1_ready_low", 32'(s_ready), 32'd0);
      @(negedge clk);
      check("t1_ready_back", 32'(s_ready), 32'd1);
      tick();
      drain();
      exp_q = '{8'h11, 8'h22, 8'h33, 8'h83};
      compare_q("t1");
      for (int i = 1; i < cap_cyc.size(); i++)
         check($sformatf("t1_gap%0d", i), 32'(cap_cyc[i] - cap_cyc[i-1]), 32'd1);
      check("t1_fcnt", 32'(fcnt), 32'd1);
      check("t1_busy", 32'(busy), 32'd0);

      // 70-word frame splits at 63
      do_reset();
      for (int i = 1; i <= 70; i++) send_word(7'(i), (i == 70));
      drain();
      for (int i = 1; i <= 63; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'hFF);
      for (int i = 64; i <= 70; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'h87);
      compare_q("t2");
      check("t2_fcnt", 32'(fcnt), 32'd2);

      // Full held high for 5 cycles with a word in the stage
      do_reset();
      send_word(7'h2A, 1'b0);
      full_dir = 1'b1;
      s_valid  = 1'b1;
      s_data   = 7'h2B;
      s_last   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("t3_we%0d", i), 32'(we), 32'd1);
         check($sformatf("t3_din%0d", i), 32'(din), 32'h2A);
         check($sformatf("t3_rdy%0d", i), 32'(s_ready), 32'd0);
         tick();
      end
      full_dir = 1'b0;
      @(negedge clk);
      check("t3_rdy_rise", 32'(s_ready), 32'd1);
      check("t3_we_hold", 32'(we), 32'd1);
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
      drain();
      exp_q = '{8'h2A, 8'h2B, 8'h82};
      compare_q("t3");
      check("t3_fcnt", 32'(fcnt), 32'd1);

      // Back-to-back single-word frames
      do_reset();
      send_word(7'h05, 1'b1);
      a1 = last_acc;
      send_word(7'h06, 1'b1);
      a2 = last_acc;
      check("t4_acc_gap", 32'(a2 - a1), 32'd2);
      drain();
      exp_q = '{8'h05, 8'h81, 8'h06, 8'h81};
      compare_q("t4");
      check("t4_fcnt", 32'(fcnt), 32'd2);

      // Reset after word 2 of a 4-word frame (frame_count is 2 going in)
      clear_q();
      send_word(7'h01, 1'b0);
      send_word(7'h02, 1'b0);
      rst_b = 1'b0;
      #2;
      check("t5_we", 32'(we), 32'd0);
      check("t5_din", 32'(din), 32'd0);
      check("t5_fcnt", 32'(fcnt), 32'd0);
      check("t5_ready", 32'(s_ready), 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      tick();
      rst_b = 1'b1;
      tick();
      clear_q();
      send_word(7'h0A, 1'b0);
      send_word(7'h0B, 1'b0);
      send_word(7'h0C, 1'b1);
      drain();
      exp_q = '{8'h0A, 8'h0B, 8'h0C, 8'h83};
      compare_q("t5");
      check("t5_fcnt_after", 32'(fcnt), 32'd1);

      // Random valid gaps and Full, 1000 frames
      do_reset();
      rand_mode = 1'b1;
      ntr = 0;
      chunk = 0;
      for (int f = 0; f < 1000; f++) begin
         flen = (f % 50 == 49) ? int'($urandom_range(60, 140)) : int'($urandom_range(1, 20));
         for (int w = 0; w < flen; w++) begin
            if ($urandom_range(0, 3) == 0) begin
               for (int g = 0; g < int'($urandom_range(1, 2)); g++) tick();
            end
            d = 7'($urandom_range(0, 127));
            send_word(d, (w == flen - 1));
            exp_q.push_back({1'b0, d});
            chunk++;
            if (w == flen - 1) begin
               exp_q.push_back(8'h80 | 8'(chunk));
               ntr++;
               chunk = 0;
            end else if (chunk == 63) begin
               exp_q.push_back(8'hC0 | 8'(chunk));
               ntr++;
               chunk = 0;
            end
         end
      end
      rand_mode = 1'b0;
      drain();
      compare_q("t6");
      check("t6_fcnt", 32'(fcnt), 32'(16'(ntr)));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
